mc_ctrl: RTL

Multi-cycle control sequencer for the MIPS-subset datapath. It replaces single-cycle control with a per-instruction state machine, so that one memory port, one ALU and one register file are time-shared across the fetch, decode, execute, memory and write-back steps. It latches the fetched opcode and funct internally, drives every datapath enable and mux select, counts retired instructions, and halts on an illegal encoding.

---
 rtl/mc_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control sequencer for the MIPS-subset datapath.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB so that one memory
// port, one ALU and one register file can be shared between the steps.
// The opcode and funct are latched at the end of FETCH. Every datapath
// enable and mux select is driven from here. Retired instructions are
// counted, and an illegal encoding parks the block in HALT until reset.
//
// Ports
//   clk           rising-edge clock
//   resetN        synchronous active-low reset
//   instr         memory read data (sampled at the end of FETCH)
//   aluZero       ALU flags; the datapath uses them for the BNE decision
//   aluOverflow
//   pcWe, irWe, memWe, regWe   write enables, all gated by resetN
//   memAddrSel    0 = PC, 1 = ALU result
//   regWAddrCtrl  0 = rt, 1 = rd, 2 = r31
//   regDInCtrl    0 = ALU, 1 = memory data, 2 = PC+4
//   aluBSrcCtrl   0 = rt data, 1 = sign-extended immediate
//   aluCmd        0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT
//   pcSrcCtrl     0 = PC+4, 1 = jump target, 2 = rs data, 3 = branch result
//   state         current state encoding
//   retired       completed-instruction count (wraps)
//   halted        high while in HALT
//
// state  | meaning
// -------+---------------------------------------------------------
// FETCH  | read instr at PC, load IR, latch opcode/funct
// DECODE | classify instruction; illegal encodings go to HALT
// EXEC   | ALU op; jumps and branches write the PC here and finish
// MEM    | data memory access for LW/SW; SW finishes here
// WB     | register write-back and PC+4 update
// HALT   | illegal instruction seen; idle until reset

module mc_ctrl (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] instr,
  input  logic        aluZero,
  input  logic        aluOverflow,
  output logic        pcWe,
  output logic        irWe,
  output logic        memAddrSel,
  output logic        memWe,
  output logic        regWe,
  output logic [1:0]  regWAddrCtrl,
  output logic [1:0]  regDInCtrl,
  output logic        aluBSrcCtrl,
  output logic [2:0]  aluCmd,
  output logic [1:0]  pcSrcCtrl,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_SLT, I_JR, I_ADDI, I_XORI,
    I_LW, I_SW, I_BNE, I_J, I_JAL, I_ILL
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  state_e      state_q, state_d;
  logic [5:0]  opcode_q;
  logic [5:0]  funct_q;
  logic [31:0] retired_q;

  instr_e      kind;
  logic [2:0]  alu_cmd_k;
  logic        alu_b_k;
  logic        pc_we_raw, ir_we_raw, mem_we_raw, reg_we_raw;

  // Only the opcode/funct fields matter to control; the ALU flags are
  // consumed by the datapath's branch logic, not here.
  logic        unused_inputs;
  assign unused_inputs = ^{instr[25:6], aluZero, aluOverflow};

  always_comb begin
    kind = I_ILL;
    case (opcode_q)
      OP_RTYPE: begin
        case (funct_q)
          FN_ADD:  kind = I_ADD;
          FN_SUB:  kind = I_SUB;
          FN_SLT:  kind = I_SLT;
          FN_JR:   kind = I_JR;
          default: kind = I_ILL;
        endcase
      end
      OP_J:    kind = I_J;
      OP_JAL:  kind = I_JAL;
      OP_BNE:  kind = I_BNE;
      OP_ADDI: kind = I_ADDI;
      OP_XORI: kind = I_XORI;
      OP_LW:   kind = I_LW;
      OP_SW:   kind = I_SW;
      default: kind = I_ILL;
    endcase
  end

  // ALU setting chosen in EXEC; WB keeps the same values so the ALU result
  // stays stable while the register file captures it.
  always_comb begin
    alu_cmd_k = ALU_ADD;
    alu_b_k   = 1'b0;
    case (kind)
      I_SUB:  alu_cmd_k = ALU_SUB;
      I_SLT:  alu_cmd_k = ALU_SLT;
      I_BNE:  alu_cmd_k = ALU_SUB;
      I_ADDI: alu_b_k   = 1'b1;
      I_XORI: begin
        alu_cmd_k = ALU_XOR;
        alu_b_k   = 1'b1;
      end
      I_LW:   alu_b_k   = 1'b1;
      I_SW:   alu_b_k   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (kind == I_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (kind)
          I_ADD, I_SUB, I_SLT, I_ADDI, I_XORI: state_d = S_WB;
          I_LW, I_SW:                          state_d = S_MEM;
          default:                             state_d = S_FETCH;
        endcase
      end
      S_MEM:    state_d = (kind == I_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    pc_we_raw    = 1'b0;
    ir_we_raw    = 1'b0;
    mem_we_raw   = 1'b0;
    reg_we_raw   = 1'b0;
    memAddrSel   = 1'b0;
    regWAddrCtrl = 2'd0;
    regDInCtrl   = 2'd0;
    aluBSrcCtrl  = 1'b0;
    aluCmd       = ALU_ADD;
    pcSrcCtrl    = 2'd0;
    case (state_q)
      S_FETCH: ir_we_raw = 1'b1;
      S_EXEC: begin
        aluCmd      = alu_cmd_k;
        aluBSrcCtrl = alu_b_k;
        case (kind)
          I_BNE: begin
            pcSrcCtrl = 2'd3;
            pc_we_raw = 1'b1;
          end
          I_J: begin
            pcSrcCtrl = 2'd1;
            pc_we_raw = 1'b1;
          end
          I_JAL: begin
            pcSrcCtrl    = 2'd1;
            pc_we_raw    = 1'b1;
            reg_we_raw   = 1'b1;
            regWAddrCtrl = 2'd2;
            regDInCtrl   = 2'd2;
          end
          I_JR: begin
            pcSrcCtrl = 2'd2;
            pc_we_raw = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        memAddrSel  = 1'b1;
        aluCmd      = ALU_ADD;
        aluBSrcCtrl = 1'b1;
        if (kind == I_SW) begin
          mem_we_raw = 1'b1;
          pc_we_raw  = 1'b1;
        end
      end
      S_WB: begin
        reg_we_raw   = 1'b1;
        pc_we_raw    = 1'b1;
        aluCmd       = alu_cmd_k;
        aluBSrcCtrl  = alu_b_k;
        regWAddrCtrl = (opcode_q == OP_RTYPE) ? 2'd1 : 2'd0;
        regDInCtrl   = (kind == I_LW) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

  // Gating with resetN guarantees no write escapes in a reset cycle, even
  // when reset lands in the middle of an instruction.
  assign pcWe  = pc_we_raw  & resetN;
  assign irWe  = ir_we_raw  & resetN;
  assign memWe = mem_we_raw & resetN;
  assign regWe = reg_we_raw & resetN;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
      end
      if (pcWe) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = (state_q == S_HALT);

endmodule
